pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_streamer.sv | 215 +++++++++++++++++++++
 tb/tb_pixel_streamer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// pixel_streamer
//   Frame buffer of N_PIXELS words, loaded over AXI4-Lite and played out as an
//   AXI-Stream-style pixel sequence on a rising edge of `start`.
//
// Ports
//   s_axi_aclk, s_axi_aresetn : clock, synchronous active-low reset
//   s_axi_aw*/w*/b*           : AXI-Lite write channel (pixel i at byte address 4*i)
//   s_axi_ar*/r*              : AXI-Lite read channel (reads allowed at any time)
//   start                     : frame trigger, rising edge only
//   x_tdata/x_tvalid/x_tready/x_tlast : pixel stream output
//   busy                      : high while a frame is streaming
//   done                      : one-cycle pulse after the last beat
module pixel_streamer #(
    parameter int unsigned N_PIXELS = 784,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    // AXI-Lite write
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    // AXI-Lite read
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    // Control and stream
    input  logic              start,
    output logic [DATA_W-1:0] x_tdata,
    output logic              x_tvalid,
    input  logic              x_tready,
    output logic              x_tlast,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W   = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
    localparam int unsigned WIDX_W  = ADDR_W - 2;
    localparam int unsigned N_LANES = ((DATA_W / 8) < 4) ? (DATA_W / 8) : 4;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PIXELS - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } state_t;

    logic [DATA_W-1:0] r_mem [N_PIXELS];

    state_t            r_state;
    state_t            w_state_d;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_d;
    logic              r_start_prev;

    logic              r_awready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_arready;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic [DATA_W-1:0] r_rdata;

    // Write-side address decode
    logic [WIDX_W-1:0] w_wr_word;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_wr_in_range;
    logic              w_wr_fire;
    logic              w_wr_ok;

    assign w_wr_word     = s_axi_awaddr[ADDR_W-1:2];
    assign w_wr_idx      = IDX_W'(w_wr_word);
    assign w_wr_in_range = (32'(w_wr_word) < N_PIXELS);
    // Address and data are only ever accepted together, so one ready covers both.
    assign w_wr_fire     = r_awready & s_axi_awvalid & s_axi_wvalid;
    // A write during a frame would corrupt the pixel currently on the stream.
    assign w_wr_ok       = w_wr_in_range & ~busy;

    // Read-side address decode
    logic [WIDX_W-1:0] w_rd_word;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_in_range;
    logic              w_rd_fire;

    assign w_rd_word     = s_axi_araddr[ADDR_W-1:2];
    assign w_rd_idx      = IDX_W'(w_rd_word);
    assign w_rd_in_range = (32'(w_rd_word) < N_PIXELS);
    assign w_rd_fire     = r_arready & s_axi_arvalid;

    logic w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Pixel memory: no reset so it maps onto RAM; contents after reset are undefined.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_aresetn && w_wr_fire && w_wr_ok) begin
            for (int b = 0; b < N_LANES; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // AXI-Lite channel registers
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            // Ready pulses for a single cycle; the ~ready term prevents a second accept.
            r_awready <= s_axi_awvalid & s_axi_wvalid & ~r_bvalid & ~r_awready;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end

            r_arready <= s_axi_arvalid & ~r_rvalid & ~r_arready;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                r_rdata  <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

    // Stream FSM state register
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            // Treat start as already high so a level held through reset cannot trigger.
            r_start_prev <= 1'b1;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_start_prev <= start;
        end
    end

    // Stream FSM next-state and outputs
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        x_tvalid  = 1'b0;
        x_tlast   = 1'b0;
        x_tdata   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && !r_start_prev) begin
                    w_state_d = StStream;
                    w_idx_d   = '0;
                end
            end
            StStream: begin
                x_tvalid = 1'b1;
                busy     = 1'b1;
                x_tdata  = r_mem[r_idx];
                x_tlast  = (r_idx == IDX_LAST);
                if (x_tready) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_d = StDone;
                        w_idx_d   = '0;
                    end else begin
                        w_idx_d = r_idx + 1'b1;
                    end
                end
            end
            StDone: begin
                done      = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer
//   Directed bench for pixel_streamer: AXI-Lite load/readback, free-running and
//   stalled frame playout, error responses, byte strobes and mid-frame reset.
module tb_pixel_streamer;

    localparam int unsigned NP = 784;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [11:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [11:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x_tdata;
    logic        x_tvalid;
    logic        x_tready = 1'b0;
    logic        x_tlast;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    pixel_streamer #(
        .N_PIXELS(NP),
        .DATA_W  (32),
        .ADDR_W  (12)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(aresetn),
        .s_axi_awaddr (awaddr),
        .s_axi_awprot (awprot),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arprot (arprot),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .start        (start),
        .x_tdata      (x_tdata),
        .x_tvalid     (x_tvalid),
        .x_tready     (x_tready),
        .x_tlast      (x_tlast),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word(input int i);
        return 32'd100000001 + 32'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one write; inputs change and outputs are sampled on the falling edge.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (awready || wready) seen = 1'b1;
        end
        check("aw_w_ready", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("bvalid_pulse", {awready, wready, bvalid}, 3'b001);
        resp  = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (arready) seen = 1'b1;
        end
        check("ar_ready", seen, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_pulse", {arready, rvalid}, 2'b01);
        data   = rdata;
        resp   = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          exp_idx;
        int          beats;
        bit          fin;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, done, x_tvalid, x_tlast, awready, wready, bvalid, arready,
                           rvalid, bresp, rresp}, '0);
        check("rst_tdata", x_tdata, '0);
        check("rst_rdata", rdata, '0);
        aresetn = 1'b1;
        @(negedge clk);

        // Load the frame and read back both ends
        for (int i = 0; i < NP; i++) begin
            axi_write(12'(4 * i), word(i), 4'hF, resp);
            check("load_bresp", resp, 2'b00);
        end
        axi_read(12'h000, data, resp);
        check("rd0_data", data, 32'h05F5E101);
        check("rd0_resp", resp, 2'b00);
        axi_read(12'hC3C, data, resp);
        check("rd_last_data", data, word(783));
        check("rd_last_resp", resp, 2'b00);
        axi_read(12'h006, data, resp);
        check("rd_lowbits_data", data, word(1));

        // Frame with x_tready held high: 784 back-to-back beats then done
        x_tready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int b = 0; b < NP; b++) begin
            check("beat", {x_tvalid, x_tlast, busy, done, x_tdata},
                  {1'b1, (b == NP - 1), 1'b1, 1'b0, word(b)});
            @(negedge clk);
        end
        check("done_pulse", {done, busy, x_tvalid, x_tlast}, 4'b1000);
        @(negedge clk);
        check("after_done", {done, busy, x_tvalid}, 3'b000);
        // start still high: no retrigger
        repeat (3) @(negedge clk);
        check("no_retrigger", {busy, x_tvalid}, 2'b00);
        start = 1'b0;

        // Stalled frame with a write attempted while busy
        x_tready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        axi_write(12'h010, 32'hDEADBEEF, 4'hF, resp);
        check("busy_bresp", resp, 2'b10);
        check("stall_hold", {x_tvalid, busy, x_tdata}, {1'b1, 1'b1, word(0)});
        exp_idx = 0;
        fin     = 1'b0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            check("stall_beat", {x_tvalid, x_tlast, done, x_tdata},
                  {1'b1, (exp_idx == NP - 1), 1'b0, word(exp_idx)});
            x_tready = 1'($urandom_range(0, 1));
            if (x_tready) exp_idx++;
            if (exp_idx == NP) fin = 1'b1;
            @(negedge clk);
        end
        check("stall_finish", fin, 1'b1);
        check("stall_done", {done, busy, x_tvalid}, 3'b100);
        x_tready = 1'b1;
        @(negedge clk);

        // Byte strobes
        axi_write(12'h020, 32'hFFFFFFFF, 4'hF, resp);
        axi_write(12'h020, 32'h12345678, 4'b0011, resp);
        check("strb_bresp", resp, 2'b00);
        axi_read(12'h020, data, resp);
        check("strb_data", data, 32'hFFFF5678);

        // Busy write left memory untouched
        axi_read(12'h010, data, resp);
        check("busy_unchanged", data, word(4));

        // Out-of-range access
        axi_write(12'hC40, 32'hCAFEF00D, 4'hF, resp);
        check("oor_bresp", resp, 2'b10);
        axi_read(12'hC40, data, resp);
        check("oor_rdata", data, 32'h0);
        check("oor_rresp", resp, 2'b10);
        axi_read(12'h020, data, resp);
        check("oor_wr_no_alias", data, 32'hFFFF5678);
        // Leave rresp=SLVERR and nonzero rdata/bresp visible for the reset check
        axi_read(12'hFFC, data, resp);
        axi_write(12'hFFC, 32'h1, 4'hF, resp);
        axi_read(12'h020, data, resp);

        // Mid-frame reset at beat 300, start held high across it
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 300; b++) @(negedge clk);
        check("pre_rst_beat", {x_tvalid, busy, x_tdata}, {1'b1, 1'b1, word(300)});
        aresetn = 1'b0;
        @(negedge clk);
        check("mid_rst_ctrl", {busy, done, x_tvalid, x_tlast, awready, wready, bvalid, arready,
                               rvalid, bresp, rresp}, '0);
        check("mid_rst_tdata", x_tdata, '0);
        check("mid_rst_rdata", rdata, '0);
        @(negedge clk);
        aresetn = 1'b1;
        fin = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy || done || x_tvalid) fin = 1'b1;
        end
        check("post_rst_quiet", fin, 1'b0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("restart", {busy, x_tvalid, done}, 3'b110);
        beats = 0;
        fin   = 1'b0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            if (done) fin = 1'b1;
            else if (x_tvalid && x_tready) beats++;
            if (!fin) @(negedge clk);
        end
        check("restart_done", fin, 1'b1);
        check("restart_beats", beats, NP);
        start = 1'b0;
        @(negedge clk);
        check("final_idle", {busy, done, x_tvalid}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
